// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand request and result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             V;
  modport master (output start, A, B, Bin, input busy, done, Diff, Bout, V);
  modport slave (input start, A, B, Bin, output busy, done, Diff, Bout, V);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one full-subtractor cell and a borrow flop
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] ra, rb, res;
  logic [CW-1:0]    cnt;
  logic             br, sa, sb, d, bn, last, accept;
  always_comb begin
    d      = ra[0] ^ rb[0] ^ br;
    bn     = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    last   = cnt == CW'(WIDTH - 1);
    accept = bus.start && state != SHIFT;
    nxt    = accept ? SHIFT : (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
  // sign bits are kept separately because ra/rb are consumed by the shift
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      res      <= '0;
      br       <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      cnt      <= '0;
      bus.Diff <= '0;
      bus.Bout <= 1'b0;
      bus.V    <= 1'b0;
    end else if (accept) begin
      ra  <= bus.A;
      rb  <= bus.B;
      br  <= bus.Bin;
      sa  <= bus.A[WIDTH-1];
      sb  <= bus.B[WIDTH-1];
      cnt <= '0;
    end else if (state == SHIFT) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      br  <= bn;
      res <= {d, res[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      if (last) begin
        bus.Diff <= {d, res[WIDTH-1:1]};
        bus.Bout <= bn;
        bus.V    <= (sa ^ sb) & (sa ^ d);
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of latency, results, handshake and async reset
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0, passed = 0, failed = 0;
  int   lat, bc, dc;
  serial_subtractor_if #(.WIDTH(8)) bus ();
  serial_subtractor #(.WIDTH(8), .CW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // counts edges from the accepting edge (as 1) until done is seen
  task automatic wait_done(output int l, output int b);
    l = 1; b = 0;
    while (!bus.done && l < 20) begin
      if (bus.busy) b++;
      tick();
      l++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic ev);
    launch(a, b, bin);
    wait_done(lat, bc);
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_diff"}, bus.Diff, ed);
    chk({tag, "_bout"}, bus.Bout, eb);
    chk({tag, "_v"}, bus.V, ev);
    tick();
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_hold"}, bus.Diff, ed);
  endtask

  initial begin
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.Diff, 0);
    chk("rst_bout", bus.Bout, 0);
    chk("rst_v", bus.V, 0);
    rst = 1'b0;
    tick();
    run("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    chk("5a_3c_busy_cycles", bc, 8);
    run("00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run("10_0f_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run("80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run("7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    // start pulse during SHIFT must be ignored
    launch(8'h33, 8'h11, 1'b0);
    tick(); tick();
    bus.A = 8'hFF; bus.B = 8'h00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_busy", bus.busy, 1);
    lat = 4; bc = 0;
    while (!bus.done && lat < 20) begin tick(); lat++; end
    chk("ign_lat", lat, 9);
    chk("ign_diff", bus.Diff, 8'h22);
    dc = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.done) dc++; end
    chk("ign_done_once", dc, 0);
    chk("ign_idle", bus.busy, 0);
    // start held across DONE relaunches with no idle gap
    bus.A = 8'h33; bus.B = 8'h11; bus.Bin = 1'b0; bus.start = 1'b1;
    tick();
    bus.A = 8'h09; bus.B = 8'h0A;
    wait_done(lat, bc);
    chk("held_lat1", lat, 9);
    chk("held_diff1", bus.Diff, 8'h22);
    tick();
    bus.start = 1'b0;
    chk("held_no_idle", bus.busy, 1);
    wait_done(lat, bc);
    chk("held_lat2", lat, 9);
    chk("held_diff2", bus.Diff, 8'hFF);
    chk("held_bout2", bus.Bout, 1);
    chk("held_v2", bus.V, 0);
    tick();
    // reset mid-operation
    launch(8'h5A, 8'h3C, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_diff", bus.Diff, 0);
    chk("mid_rst_bout", bus.Bout, 0);
    chk("mid_rst_v", bus.V, 0);
    dc = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.done) dc++; end
    chk("mid_rst_no_done", dc, 0);
    rst = 1'b0;
    run("05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes Diff = A - B - Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Companion to the team's combinational CLA-based adders. Gives the inverse operation (subtraction) where area matters more than latency.
- Used by the datapath's multi-cycle ALU slot: the controller pulses start and waits for done.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CW, 4, counter width; must satisfy 2^CW >= WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on a rising edge of clk.
- A  input  WIDTH  minuend; captured when start is accepted.
- B  input  WIDTH  subtrahend; captured when start is accepted.
- Bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse when a result is valid.
- Diff  output  WIDTH  result A - B - Bin, modulo 2^WIDTH.
- Bout  output  1  unsigned borrow-out; high when A < B + Bin.
- V  output  1  signed overflow flag.

Behaviour:
- Reset: asynchronous and active-high. Clock is clk, reset is rst. While rst=1: state=IDLE, busy=0, done=0, Diff=0, Bout=0, V=0, all internal shift registers, the borrow flip-flop and the counter are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 -> latch A into shift register ra, B into rb and Bin into br; set cnt=0; go to SHIFT.
- SHIFT: each cycle processes one bit:
  - d = ra[0] ^ rb[0] ^ br
  - br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)
  - d is shifted into the result register from the MSB end; ra and rb shift right by 1; cnt increments.
  - When cnt = WIDTH-1 (the last bit), go to DONE on the next edge.
- DONE, held for exactly one cycle:
  - done=1.
  - Diff = the completed result register.
  - Bout = final borrow.
  - V = (A[MSB] ^ B[MSB]) & (A[MSB] ^ Diff[MSB]), using the captured copies of the A and B sign bits.
  - Then go to IDLE.
- Latency: start accepted on edge t -> done high in the cycle after edge t+WIDTH, i.e. WIDTH+1 cycles after acceptance (9 cycles for WIDTH=8).
- Output registers: Diff, Bout and V are output registers. They update only on entry to DONE and hold their value until the next completion or reset. Partial results are never visible on Diff.
- busy: 1 exactly in SHIFT.
- Handshake:
  - start is accepted in IDLE and in DONE, so back-to-back operations are allowed.
  - In DONE, start=1 latches new operands and goes to SHIFT instead of IDLE. done is still 1 for that cycle.
  - start is ignored while busy=1; operands presented then are not captured.
- Input stability: A, B and Bin matter only in the acceptance cycle. Later changes have no effect on the operation in progress.
- Held start: if start is held high continuously, the block re-launches on every DONE cycle using the current operands.
- Wrap-around: Diff is always modulo 2^WIDTH. A borrow beyond the MSB appears only on Bout.
- Reset mid-operation: the operation is aborted and no done pulse is issued. Outputs return to 0 asynchronously.
- Reset release: the first edge after rst deasserts may accept start.

Test Plan:
- A=0x5A, B=0x3C, Bin=0, start pulse -> done exactly 9 cycles later, Diff=0x1E, Bout=0, V=0; busy high for 8 cycles.
- A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1, V=0. Then A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Bout=0.
- A=0x80, B=0x01 -> Diff=0x7F, V=1, Bout=0. A=0x7F, B=0xFF -> Diff=0x80, V=1, Bout=1.
- Start 0x33-0x11, then pulse start with A=0xFF, B=0x00 at cycle 3 of SHIFT -> second request ignored; Diff=0x22; done pulses once.
- Start held high across DONE with new operands 0x09-0x0A -> done pulses for 0x22, then 9 cycles later Diff=0xFF, Bout=1; no idle cycle in between.
- Assert rst during cycle 4 of SHIFT -> busy, done, Diff, Bout and V go to 0 immediately with no done pulse. After release, a new start 0x05-0x03 gives Diff=0x02.
